// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin arbiter sharing one single-port SRAM between two native masters
module sram_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_valid,
  input  logic [31:0]         m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ready,
  input  logic                m1_valid,
  input  logic [31:0]         m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ready,
  output logic                sram_csb0,
  output logic                sram_web0,
  output logic [ADDR_W-1:0]   sram_addr0,
  output logic [DATA_W-1:0]   sram_din0,
  input  logic [DATA_W-1:0]   sram_dout0
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_MERGE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                id_q;        // granted master
  logic                prio_q;      // master favoured on contention (0 = m0)
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   data_q;      // word captured from the macro
  logic [CNT_W-1:0]    cnt_q;
  logic                grant_id;
  logic                full_wr;
  logic                is_read;
  logic                wait_last;
  logic [DATA_W-1:0]   merged;

  assign full_wr   = &wstrb_q;
  assign is_read   = (wstrb_q == '0);
  assign wait_last = (cnt_q == CNT_W'(READ_LAT - 1));
  assign grant_id  = (m0_valid && m1_valid) ? prio_q : m1_valid;

  // Byte merge of the captured word with the strobed write bytes for read-modify-write.
  always_comb begin
    merged = '0;
    for (int i = 0; i < STRB_W; i++) begin
      merged[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : data_q[8*i +: 8];
    end
  end

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (m0_valid || m1_valid) state_d = S_ACCESS;
      S_ACCESS: state_d = full_wr ? S_DONE : S_WAIT;
      S_WAIT:   if (wait_last) state_d = is_read ? S_DONE : S_MERGE;
      S_MERGE:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register plus request latching, wait counter, data capture and round-robin update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (m0_valid || m1_valid) begin
            id_q    <= grant_id;
            addr_q  <= grant_id ? m1_addr[ADDR_W+1:2] : m0_addr[ADDR_W+1:2];
            wdata_q <= grant_id ? m1_wdata : m0_wdata;
            wstrb_q <= grant_id ? m1_wstrb : m0_wstrb;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (wait_last) data_q <= sram_dout0;
        end
        S_DONE: prio_q <= ~id_q;
        default: ;
      endcase
    end
  end

  // Outputs are decoded purely from registered state.
  always_comb begin
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = '0;
    if (state_q == S_ACCESS) begin
      sram_csb0  = 1'b0;
      sram_addr0 = addr_q;
      if (full_wr) begin
        sram_web0 = 1'b0;
        sram_din0 = wdata_q;
      end
    end else if (state_q == S_MERGE) begin
      sram_csb0  = 1'b0;
      sram_web0  = 1'b0;
      sram_addr0 = addr_q;
      sram_din0  = merged;
    end
  end

  assign m0_ready = (state_q == S_DONE) && !id_q;
  assign m1_ready = (state_q == S_DONE) &&  id_q;
  assign m0_rdata = (m0_ready && is_read) ? data_q : '0;
  assign m1_rdata = (m1_ready && is_read) ? data_q : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed table-driven bench for sram_arbiter with behavioural SRAM models
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init = 1'b1;

  logic        m0_valid = 0, m1_valid = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
  logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        sram_csb0, sram_web0;
  logic [9:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] dout1;

  logic        b_valid = 0;
  logic [31:0] b_addr = 0;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_m0_ready, b_m1_ready;
  logic        b_csb0, b_web0;
  logic [9:0]  b_addr0;
  logic [31:0] b_din0;
  logic [31:0] s2, dout2;

  logic [31:0] mem1 [0:1023];
  logic [31:0] mem2 [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(dout1)
  );

  sram_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LAT(2)) u2 (
    .clk(clk), .rst(rst),
    .m0_valid(b_valid), .m0_addr(b_addr), .m0_wdata(32'h0), .m0_wstrb(4'h0),
    .m0_rdata(b_m0_rdata), .m0_ready(b_m0_ready),
    .m1_valid(1'b0), .m1_addr(32'h0), .m1_wdata(32'h0), .m1_wstrb(4'h0),
    .m1_rdata(b_m1_rdata), .m1_ready(b_m1_ready),
    .sram_csb0(b_csb0), .sram_web0(b_web0), .sram_addr0(b_addr0),
    .sram_din0(b_din0), .sram_dout0(dout2)
  );

  // SRAM macro models: one-cycle and two-cycle read latency, preloaded while init is high.
  always @(posedge clk) begin
    if (init) begin
      mem1[3] <= 32'hAABBCCDD;
      mem1[4] <= 32'hDEADBEEF;
      mem1[5] <= 32'h11223344;
      mem2[7] <= 32'h0BADF00D;
    end else begin
      if (!sram_csb0 && !sram_web0) mem1[sram_addr0] <= sram_din0;
      if (!sram_csb0 &&  sram_web0) dout1 <= mem1[sram_addr0];
      if (!b_csb0 && b_web0) s2 <= mem2[b_addr0];
      dout2 <= s2;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rdata;
    logic        web1;
    logic [9:0]  waddr;
    logic [31:0] din;
  } row_t;

  row_t rows [10];

  task automatic do_req(input row_t r, input string tag);
    int          lat;
    logic [31:0] rd, din1, din3;
    logic        csb1, web1, web3, other, inv;
    logic [9:0]  adr1;
    lat = -1; rd = 0; din1 = 0; din3 = 0; csb1 = 1; web1 = 1; web3 = 1;
    adr1 = 0; other = 0; inv = 0;
    @(negedge clk);
    if (r.m) begin
      m1_valid = 1; m1_addr = r.addr; m1_wdata = r.wdata; m1_wstrb = r.wstrb;
    end else begin
      m0_valid = 1; m0_addr = r.addr; m0_wdata = r.wdata; m0_wstrb = r.wstrb;
    end
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        csb1 = sram_csb0; web1 = sram_web0; adr1 = sram_addr0; din1 = sram_din0;
      end
      if (k == 3) begin
        din3 = sram_din0; web3 = sram_web0;
      end
      if (!sram_web0 && sram_csb0) inv = 1;
      if (r.m ? m0_ready : m1_ready) other = 1;
      if (r.m ? m1_ready : m0_ready) begin
        lat = k;
        rd  = r.m ? m1_rdata : m0_rdata;
      end
    end
    m0_valid = 0; m1_valid = 0;
    chk({tag, " latency"}, lat, r.lat);
    chk({tag, " rdata"}, rd, r.rdata);
    chk({tag, " csb0 c1"}, csb1, 1'b0);
    chk({tag, " web0 c1"}, web1, r.web1);
    chk({tag, " addr0 c1"}, adr1, r.waddr);
    if (r.lat == 2) chk({tag, " din0 c1"}, din1, r.din);
    if (r.lat == 4) begin
      chk({tag, " merge din0"}, din3, r.din);
      chk({tag, " merge web0"}, web3, 1'b0);
    end
    chk({tag, " other ready"}, other, 1'b0);
    chk({tag, " web0 without csb0"}, inv, 1'b0);
  endtask

  initial begin
    int          n, cyc0, cyc1, cyc2, cyc3, lat;
    logic [3:0]  order;
    logic        both, bad, first;
    logic [31:0] rd;

    rows[0] = '{0, 32'h10,       32'h0,        4'h0, 3, 32'hDEADBEEF, 1'b1, 10'd4,   32'h0};
    rows[1] = '{1, 32'h8,        32'h12345678, 4'hF, 2, 32'h0,        1'b0, 10'd2,   32'h12345678};
    rows[2] = '{0, 32'hC,        32'h00001100, 4'h2, 4, 32'h0,        1'b1, 10'd3,   32'hAABB11DD};
    rows[3] = '{1, 32'hC,        32'h0,        4'h0, 3, 32'hAABB11DD, 1'b1, 10'd3,   32'h0};
    rows[4] = '{0, 32'h8,        32'h0,        4'h0, 3, 32'h12345678, 1'b1, 10'd2,   32'h0};
    rows[5] = '{1, 32'h1000000B, 32'h0,        4'h0, 3, 32'h12345678, 1'b1, 10'd2,   32'h0};
    rows[6] = '{1, 32'h8,        32'h000000AA, 4'h1, 4, 32'h0,        1'b1, 10'd2,   32'h123456AA};
    rows[7] = '{0, 32'h8,        32'h0,        4'h0, 3, 32'h123456AA, 1'b1, 10'd2,   32'h0};
    rows[8] = '{0, 32'hFFC,      32'hCAFEF00D, 4'hF, 2, 32'h0,        1'b0, 10'h3FF, 32'hCAFEF00D};
    rows[9] = '{1, 32'hFFC,      32'h0,        4'h0, 3, 32'hCAFEF00D, 1'b1, 10'h3FF, 32'h0};

    repeat (3) @(negedge clk);
    chk("reset csb0", sram_csb0, 1'b1);
    chk("reset web0", sram_web0, 1'b1);
    chk("reset addr0", sram_addr0, 10'd0);
    chk("reset din0", sram_din0, 32'h0);
    chk("reset ready", {m0_ready, m1_ready}, 2'b00);
    chk("reset rdata", m0_rdata | m1_rdata, 32'h0);
    rst = 0; init = 0;

    for (int i = 0; i < 10; i++) do_req(rows[i], $sformatf("row%0d", i));

    // Contention from reset: both masters valid continuously.
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    m0_valid = 1; m0_addr = 32'h10; m0_wstrb = 0;
    m1_valid = 1; m1_addr = 32'hC;  m1_wstrb = 0;
    n = 0; order = 0; both = 0; bad = 0;
    cyc0 = 0; cyc1 = 0; cyc2 = 0; cyc3 = 0;
    for (int k = 1; k <= 40 && n < 4; k++) begin
      @(negedge clk);
      if (m0_ready && m1_ready) both = 1;
      if (m0_ready || m1_ready) begin
        order = {order[2:0], m1_ready};
        if (m0_ready && m0_rdata !== 32'hDEADBEEF) bad = 1;
        if (m1_ready && m1_rdata !== 32'hAABB11DD) bad = 1;
        case (n)
          0: cyc0 = k;
          1: cyc1 = k;
          2: cyc2 = k;
          default: cyc3 = k;
        endcase
        n++;
      end
    end
    m0_valid = 0; m1_valid = 0;
    chk("contention count", n, 4);
    chk("contention order", order, 4'b0101);
    chk("contention both ready", both, 1'b0);
    chk("contention rdata", bad, 1'b0);
    chk("contention timing", {cyc0[7:0], cyc1[7:0], cyc2[7:0], cyc3[7:0]}, {8'd3, 8'd7, 8'd11, 8'd15});

    // Reset during WAIT of a partial write; pointer left favouring m1 beforehand.
    do_req(rows[0], "pre-reset m0 read");
    @(negedge clk);
    m1_valid = 1; m1_addr = 32'h14; m1_wdata = 32'h000000FF; m1_wstrb = 4'h1;
    @(negedge clk);
    chk("rmw access csb0", sram_csb0, 1'b0);
    @(negedge clk);
    chk("rmw wait csb0", sram_csb0, 1'b1);
    rst = 1;
    @(negedge clk);
    chk("post-reset csb0", sram_csb0, 1'b1);
    chk("post-reset web0", sram_web0, 1'b1);
    chk("post-reset ready", {m0_ready, m1_ready}, 2'b00);
    rst = 0; m1_valid = 0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (m0_ready || m1_ready || !sram_csb0) bad = 1;
    end
    chk("post-reset quiet", bad, 1'b0);
    chk("aborted rmw word", mem1[5], 32'h11223344);
    m0_valid = 1; m0_addr = 32'h10; m0_wstrb = 0;
    m1_valid = 1; m1_addr = 32'h14; m1_wstrb = 0;
    first = 1; rd = 0; lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        lat = k; first = m1_ready; rd = m0_rdata;
      end
    end
    m0_valid = 0; m1_valid = 0;
    chk("first grant after reset", first, 1'b0);
    chk("first grant latency", lat, 3);
    chk("first grant rdata", rd, 32'hDEADBEEF);

    // READ_LAT=2 instance.
    @(negedge clk);
    b_valid = 1; b_addr = 32'h1C;
    lat = -1; rd = 0; bad = 1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) bad = b_csb0;
      if (b_m0_ready) begin
        lat = k; rd = b_m0_rdata;
      end
    end
    b_valid = 0;
    chk("lat2 csb0 c1", bad, 1'b0);
    chk("lat2 latency", lat, 4);
    chk("lat2 rdata", rd, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
